// File: rtl/pipe_hazard_ctrl.sv
// Purpose : pipeline hazard controller; load-use stalls, branch flushes, memory-wait holds.
// Latency : hold/flush/bubble are combinational from inputs and state; status counters are registered.
// Backpr. : mem_busy holds the whole pipe (PC + IF/ID) and freezes any flush in progress.
//
// Ports:
//   clk, reset (async active-low)
//   id_rs1, id_rs2, ex_rd, ex_mem_read   -- load-use detection operands
//   if_branch                            -- taken branch resolved in ID
//   mem_busy                             -- data memory not ready
//   pc_hold, if_id_hold, if_id_flush, id_ex_bubble -- pipeline control
//   stall_code                           -- {any, timeout, mem_wait, flush, load_use}
//   mem_timeout                          -- sticky memory timeout flag
//   stall_count                          -- saturating count of pc_hold cycles
module pipe_hazard_ctrl #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        if_branch,
    input  logic        mem_busy,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [4:0]  stall_code,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LOAD  = 2'(BR_PENALTY - 1);
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  flush_cnt;
    logic [1:0]  flush_cnt_nxt;
    logic [7:0]  wait_cnt;

    logic        load_use;
    logic        resume_flush;
    logic        pc_hold_c;
    logic        if_id_hold_c;
    logic        if_id_flush_c;
    logic        id_ex_bubble_c;
    logic        mem_wait_c;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // A flush interrupted by mem_busy parks its remaining count in flush_cnt
    // while in MEM_WAIT; a non-zero count means FLUSH must resume afterwards.
    assign resume_flush = (state == FLUSH) ||
                          ((state == MEM_WAIT) && (flush_cnt != 2'd0));

    // Priority mem_busy > if_branch > load_use in every state. MEM_WAIT only
    // holds while mem_busy is high; the first free cycle already behaves as
    // the state being returned to, so no extra stall cycle is inserted.
    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        mem_wait_c     = 1'b0;

        if (mem_busy) begin
            pc_hold_c    = 1'b1;
            if_id_hold_c = 1'b1;
            mem_wait_c   = 1'b1;
            state_nxt    = MEM_WAIT;
        end else if (if_branch) begin
            if_id_flush_c = 1'b1;
            flush_cnt_nxt = FLUSH_LOAD;
            state_nxt     = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
        end else if (resume_flush) begin
            if_id_flush_c = 1'b1;
            if (flush_cnt <= 2'd1) begin
                flush_cnt_nxt = 2'd0;
                state_nxt     = RUN;
            end else begin
                flush_cnt_nxt = flush_cnt - 2'd1;
                state_nxt     = FLUSH;
            end
        end else if (load_use) begin
            pc_hold_c      = 1'b1;
            if_id_hold_c   = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_nxt      = RUN;
        end else begin
            state_nxt = RUN;
        end
    end

    // Control outputs are gated by reset so they read zero while it is held,
    // independent of whatever the inputs are doing.
    assign pc_hold      = reset & pc_hold_c;
    assign if_id_hold   = reset & if_id_hold_c;
    assign if_id_flush  = reset & if_id_flush_c;
    assign id_ex_bubble = reset & id_ex_bubble_c;

    always_comb begin
        stall_code    = 5'd0;
        stall_code[0] = id_ex_bubble;
        stall_code[1] = if_id_flush;
        stall_code[2] = reset & mem_wait_c;
        stall_code[3] = reset & mem_timeout;
        stall_code[4] = stall_code[0] | stall_code[1] | stall_code[2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            flush_cnt   <= 2'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;

            // Consecutive busy cycles; the flag sets on the edge that
            // completes the MEM_TIMEOUT-th one.
            if (mem_busy) begin
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (wait_cnt >= (TIMEOUT_LIM - 8'd1)) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end

            if (pc_hold_c && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter BR_PENALTY, default 1, meaning the number of cycles IF/ID is flushed after a taken branch (range 1..3).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of consecutive mem_busy cycles before a timeout is flagged (range 2..255).
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the instruction in EX is a load.
- if_branch  in  1  a taken branch has been resolved in ID this cycle.
- mem_busy  in  1  data memory is not ready; the whole pipe must hold.
- pc_hold  out  1  PC must not update.
- if_id_hold  out  1  IF/ID register must keep its contents.
- if_id_flush  out  1  IF/ID register must load a bubble (pc 0, inst NOP).
- id_ex_bubble  out  1  ID/EX must load a NOP.
- stall_code  out  5  hazard status vector.
- mem_timeout  out  1  sticky timeout flag.
- stall_count  out  16  saturating count of stalled cycles.

Function
REQ-004 The block SHALL implement the FSM states RUN, FLUSH and MEM_WAIT in a registered state variable.
REQ-005 The load-use hazard SHALL be load_use = ex_mem_read AND ex_rd != 0 AND (ex_rd == id_rs1 OR ex_rd == id_rs2).
REQ-006 Priority SHALL be mem_busy > if_branch > load_use, evaluated every cycle and in every state.
REQ-007 In RUN with mem_busy=1, the block SHALL assert pc_hold, if_id_hold and id_ex_bubble=0 combinationally and go to MEM_WAIT.
REQ-008 In RUN with mem_busy=0 and if_branch=1, the block SHALL assert if_id_flush in the same cycle, with pc_hold=0, load a flush counter with BR_PENALTY-1, and go to FLUSH if BR_PENALTY>1, otherwise stay in RUN.
REQ-009 In RUN with only load_use=1, the block SHALL assert pc_hold, if_id_hold and id_ex_bubble for exactly that cycle and stay in RUN; a persisting load_use SHALL re-stall each cycle.
REQ-010 In FLUSH, the block SHALL assert if_id_flush, decrement the flush counter each cycle, and return to RUN after the cycle in which the counter reads 1.
REQ-011 A new if_branch arriving in FLUSH SHALL reload the flush counter with BR_PENALTY-1.
REQ-012 In MEM_WAIT, the block SHALL assert pc_hold and if_id_hold, keep if_id_flush=0 and id_ex_bubble=0, and return to RUN on the first cycle with mem_busy=0.
REQ-013 mem_busy asserting during FLUSH SHALL freeze the flush counter; the block SHALL enter MEM_WAIT and resume FLUSH with the remaining count afterwards.
REQ-014 An 8-bit wait counter SHALL count consecutive MEM_WAIT cycles; when it reaches MEM_TIMEOUT, mem_timeout SHALL set and stay set until reset.
REQ-015 stall_code bits SHALL be: [0] load_use stall active, [1] flush active, [2] mem wait active, [3] mem_timeout, [4] OR of bits 0..2.
REQ-016 stall_count SHALL increment on every cycle in which pc_hold=1 and SHALL saturate at 16'hFFFF.
REQ-017 if_id_hold and if_id_flush SHALL never both be 1 in the same cycle.

Reset
REQ-018 When reset=0, the block SHALL asynchronously force: state=RUN, all counters=0, mem_timeout=0 and stall_count=0.
REQ-019 While reset=0, all hold, flush and bubble outputs and stall_code SHALL read 0.
REQ-020 Reset asserted during FLUSH or MEM_WAIT SHALL abort the operation, and the first cycle after release SHALL be RUN.

Verification
REQ-021 Load-use test: ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_hold=if_id_hold=id_ex_bubble=1 for 1 cycle, stall_code=5'b10001, stall_count=1.
REQ-022 x0 test: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall, stall_code=0.
REQ-023 Branch test with BR_PENALTY=2: if_branch=1 for 1 cycle -> if_id_flush=1 for 2 consecutive cycles, then RUN, pc_hold=0 throughout.
REQ-024 Priority test: mem_busy=1, if_branch=1 and load_use=1 in the same cycle -> MEM_WAIT, if_id_flush=0, id_ex_bubble=0, stall_code=5'b10100.
REQ-025 Timeout test with MEM_TIMEOUT=16: mem_busy=1 for 20 cycles -> mem_timeout rises on the 16th wait cycle and stays 1 after mem_busy=0, stall_count=20.
REQ-026 Reset test: reset=0 mid-MEM_WAIT, asynchronously to clk -> outputs go 0 immediately, and after release the state is RUN with stall_count=0.
